operand_gate_feeder: RTL

OPERAND_GATE_FEEDER -- requirements
Module: operand_gate_feeder

---
 rtl/operand_feeder_pkg.sv | 14 +
 rtl/operand_fifo.sv | 70 +++++++
 rtl/operand_gate_feeder.sv | 120 ++++++++++++
 3 files changed

// File: rtl/operand_feeder_pkg.sv
// Shared defaults, state encoding and counter width for the operand gate feeder.
package operand_feeder_pkg;

    localparam int unsigned W_DEF      = 4;
    localparam int unsigned DEPTH_DEF  = 4;
    localparam int unsigned SKIP_W     = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        FLUSH = 2'd2
    } feeder_state_e;

endpackage

// File: rtl/operand_fifo.sv
// Operand-pair FIFO: power-of-two depth, wrapping pointers, occupancy count, flush clear.
module operand_fifo
    import operand_feeder_pkg::*;
#(
    parameter int unsigned W     = W_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned AW    = $clog2(DEPTH),
    parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [W-1:0]  wr_a_i,
    input  logic [W-1:0]  wr_b_i,
    output logic [W-1:0]  rd_a_c,
    output logic [W-1:0]  rd_b_c,
    output logic          full_c,
    output logic          empty_c,
    output logic [CW-1:0] count_o
);

    logic [2*W-1:0] mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = AW'(wr_ptr_q + 1'b1);
            if (pop_i)  rd_ptr_d = AW'(rd_ptr_q + 1'b1);
            case ({push_i, pop_i})
                2'b10:   count_d = CW'(count_q + 1'b1);
                2'b01:   count_d = CW'(count_q - 1'b1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; occupancy is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (push_i && !clr_i) mem_q[wr_ptr_q] <= {wr_a_i, wr_b_i};
    end

    assign {rd_a_c, rd_b_c} = mem_q[rd_ptr_q];
    assign full_c           = (count_q == CW'(DEPTH));
    assign empty_c          = (count_q == '0);
    assign count_o          = count_q;

endmodule

// File: rtl/operand_gate_feeder.sv
// Feeds queued operand pairs to an approximate multiplier, gating its enable
// and suppressing back-to-back duplicate pairs.
module operand_gate_feeder
    import operand_feeder_pkg::*;
#(
    parameter int unsigned W     = W_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W-1:0]      in_a,
    input  logic [W-1:0]      in_b,
    output logic [W-1:0]      mult_a,
    output logic [W-1:0]      mult_b,
    output logic              mult_en,
    output logic [SKIP_W-1:0] skip_count,
    output logic              busy
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    feeder_state_e     state_q, state_d;
    logic [W-1:0]      mult_a_q, mult_a_d;
    logic [W-1:0]      mult_b_q, mult_b_d;
    logic              mult_en_q, mult_en_d;
    logic              held_q, held_d;
    logic [SKIP_W-1:0] skip_q, skip_d;

    logic              push_c, pop_c, dup_c;
    logic              full_c, empty_c;
    logic [W-1:0]      rd_a_c, rd_b_c;
    logic [CW-1:0]     count;

    operand_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (flush),
        .push_i  (push_c),
        .pop_i   (pop_c),
        .wr_a_i  (in_a),
        .wr_b_i  (in_b),
        .rd_a_c  (rd_a_c),
        .rd_b_c  (rd_b_c),
        .full_c  (full_c),
        .empty_c (empty_c),
        .count_o (count)
    );

    assign in_ready = !full_c && !flush && !rst && (state_q != FLUSH);
    assign push_c   = in_valid && in_ready;
    assign pop_c    = !empty_c && (state_q == ISSUE) && !flush && !rst;
    assign dup_c    = held_q && (rd_a_c == mult_a_q) && (rd_b_c == mult_b_q);

    // Next state plus output-register updates.
    always_comb begin
        state_d   = state_q;
        mult_a_d  = mult_a_q;
        mult_b_d  = mult_b_q;
        mult_en_d = 1'b0;
        held_d    = held_q;
        skip_d    = skip_q;
        if (flush) begin
            state_d = FLUSH;
            held_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!empty_c) state_d = ISSUE;
                end
                ISSUE: begin
                    if (pop_c) begin
                        if (dup_c) begin
                            if (skip_q != '1) skip_d = SKIP_W'(skip_q + 1'b1);
                        end else begin
                            mult_a_d  = rd_a_c;
                            mult_b_d  = rd_b_c;
                            mult_en_d = 1'b1;
                            held_d    = 1'b1;
                        end
                    end
                    if (!push_c && (empty_c || (pop_c && count == CW'(1))))
                        state_d = IDLE;
                end
                FLUSH:   state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            mult_a_q  <= '0;
            mult_b_q  <= '0;
            mult_en_q <= 1'b0;
            held_q    <= 1'b0;
            skip_q    <= '0;
        end else begin
            state_q   <= state_d;
            mult_a_q  <= mult_a_d;
            mult_b_q  <= mult_b_d;
            mult_en_q <= mult_en_d;
            held_q    <= held_d;
            skip_q    <= skip_d;
        end
    end

    assign mult_a     = mult_a_q;
    assign mult_b     = mult_b_q;
    assign mult_en    = mult_en_q;
    assign skip_count = skip_q;
    assign busy       = !empty_c || mult_en_q;

endmodule
